// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM of the multi-cycle RV32I-subset CPU. The FSM steps the
//   shared ALU, memory, IR, PC and register file through the IF/ID/EX/MEM/WB
//   cycles. It handles add/sub, addi, lw, sw, beq and jal. It stalls on memory
//   through mem_ready and traps illegal opcodes into a sticky ERR state.
//
//   Parameters
//     USE_MEM_READY : 1 = honour mem_ready, 0 = memory always completes in one cycle
//
//   Ports
//     clk           in   system clock, rising edge
//     rst           in   synchronous active-high reset
//     opcode[6:0]   in   IR[6:0], valid from ID onward
//     mem_ready     in   memory completes the current access this cycle
//     pc_write      out  unconditional PC load
//     pc_write_cond out  PC load if ALU zero
//     i_or_d        out  memory address select (0 = PC, 1 = ALUOut)
//     mem_read      out  memory read request
//     mem_write     out  memory write request
//     ir_write      out  IR load (also latches oldPC)
//     mem_to_reg    out  write-back select (00 ALUOut, 01 MDR, 10 PC)
//     reg_write     out  register file write
//     alu_src_a     out  ALU A select (00 PC, 01 reg A, 10 oldPC)
//     alu_src_b     out  ALU B select (00 reg B, 01 4, 10 imm)
//     alu_op        out  ALU control (00 add, 01 sub, 10 funct-decoded)
//     pc_source     out  PC input select (0 ALU result, 1 ALUOut)
//     err           out  illegal-opcode trap, sticky until rst
//     state[3:0]    out  current state, debug
module multicycle_control #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_source,
  output logic       err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EX_R     = 4'd6,
    S_EX_I     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERR      = 4'd15
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t state_q;
  state_t state_d;
  logic   rdy;

  // With single-cycle memory the ready input is ignored entirely.
  assign rdy   = USE_MEM_READY ? mem_ready : 1'b1;
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 1'b0;
    err           = 1'b0;

    unique case (state_q)
      S_IF: begin
        // PC+4 is computed every IF cycle. PC and IR only load once the fetch completes.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) state_d = S_ID;
      end
      S_ID: begin
        // The branch/jump target oldPC+imm is prepared speculatively in ALUOut.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:               state_d = S_EX_R;
          OP_I:               state_d = S_EX_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BEQ:             state_d = S_BEQ;
          OP_JAL:             state_d = S_JAL;
          default:            state_d = S_ERR;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_IF;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (rdy) state_d = S_IF;
      end
      S_EX_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_EX_I: begin
        // addi always adds: funct7 bits belong to the immediate here.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        state_d   = S_IF;
      end
      S_BEQ: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        state_d       = S_IF;
      end
      S_JAL: begin
        // PC already holds PC+4 from IF, so it is the link value.
        pc_write   = 1'b1;
        pc_source  = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        state_d    = S_IF;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_ERR;
      end
      default: state_d = S_ERR;
    endcase

    // Reset blanks every request and write so nothing is committed in the reset cycle.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 1'b0;
      err           = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0;
  logic       mem_ready = 1'b1;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op;
  logic       reg_write, pc_source, err;
  logic [3:0] state;

  logic       n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
  logic [1:0] n_mem_to_reg, n_alu_src_a, n_alu_src_b, n_alu_op;
  logic       n_reg_write, n_pc_source, n_err;
  logic [3:0] n_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .err(err), .state(state)
  );

  multicycle_control #(.USE_MEM_READY(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .i_or_d(n_i_or_d),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
    .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .pc_source(n_pc_source),
    .err(n_err), .state(n_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles, then one R-type instruction.
  task automatic test_reset_rtype();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    rst = 1'b1; opcode = 7'b0110011; mem_ready = 1'b1;
    step();
    step();
    #1;
    total++; if ({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write} !== 6'b0) begin bad++; $display("FAIL reset_enables got=%b exp=000000", {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write}); end
    total++; if (err !== 1'b0 || state !== 4'd0) begin bad++; $display("FAIL reset_state err=%b state=%0d exp err=0 state=0", err, state); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL rtype_state cyc=%0d got=%0d exp=%0d", i, state, es[i]); end
      total++; if (alu_op !== ((i == 2) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL rtype_alu_op cyc=%0d got=%b", i, alu_op); end
      total++; if (reg_write !== (i == 3)) begin bad++; $display("FAIL rtype_reg_write cyc=%0d got=%b", i, reg_write); end
      if (i == 0) begin
        total++; if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b11101) begin bad++; $display("FAIL rtype_if got=%b exp=11101", {mem_read, ir_write, pc_write, alu_src_b}); end
      end
      if (i == 1) begin
        total++; if ({alu_src_a, alu_src_b} !== 4'b1010) begin bad++; $display("FAIL rtype_id_src got=%b exp=1010", {alu_src_a, alu_src_b}); end
      end
      if (i == 3) begin
        total++; if (mem_to_reg !== 2'b00) begin bad++; $display("FAIL rtype_mem_to_reg got=%b exp=00", mem_to_reg); end
      end
      if (i < 4) step();
    end
  endtask

  // lw with a 2-cycle IF stall and a 3-cycle MEM_RD stall.
  task automatic test_lw_waits();
    logic [3:0] es [11] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4, 0};
    logic       mr [11] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    int ir_cnt = 0;
    int pw_cnt = 0;
    int ir_cyc = -1;
    opcode = 7'b0000011;
    for (int i = 0; i < 11; i++) begin
      mem_ready = mr[i];
      #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, state, es[i]); end
      if (i < 10) begin
        if (ir_write) begin ir_cnt++; ir_cyc = i; end
        if (pc_write) pw_cnt++;
      end
      if (es[i] == 4'd3) begin
        total++; if ({mem_read, i_or_d} !== 2'b11) begin bad++; $display("FAIL lw_memrd got=%b exp=11", {mem_read, i_or_d}); end
      end
      if (i == 9) begin
        total++; if ({reg_write, mem_to_reg} !== 3'b101) begin bad++; $display("FAIL lw_wb got=%b exp=101", {reg_write, mem_to_reg}); end
      end
      if (i < 10) step();
    end
    total++; if (ir_cnt != 1 || ir_cyc != 2) begin bad++; $display("FAIL lw_ir_pulse count=%0d cyc=%0d exp count=1 cyc=2", ir_cnt, ir_cyc); end
    total++; if (pw_cnt != 1) begin bad++; $display("FAIL lw_pc_pulse count=%0d exp=1", pw_cnt); end
  endtask

  // sw with one wait cycle in MEM_WR.
  task automatic test_sw();
    logic [3:0] es [6] = '{0, 1, 2, 5, 5, 0};
    logic       mr [6] = '{1, 1, 1, 0, 1, 1};
    int mw_cnt = 0;
    opcode = 7'b0100011;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      #1;
      total++; if (state !== es[i]) begin bad++; $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", i, state, es[i]); end
      total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL sw_reg_write cyc=%0d got=%b exp=0", i, reg_write); end
      if (i < 5 && mem_write) mw_cnt++;
      if (es[i] == 4'd5) begin
        total++; if ({mem_write, i_or_d} !== 2'b11) begin bad++; $display("FAIL sw_memwr cyc=%0d got=%b exp=11", i, {mem_write, i_or_d}); end
      end
      if (i < 5) step();
    end
    total++; if (mw_cnt != 2) begin bad++; $display("FAIL sw_mem_write_cycles got=%0d exp=2", mw_cnt); end
  endtask

  task automatic test_beq_jal();
    mem_ready = 1'b1;
    opcode = 7'b1100011;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL beq_start got=%0d exp=0", state); end
    step(); step();
    total++; if (state !== 4'd9) begin bad++; $display("FAIL beq_state got=%0d exp=9", state); end
    total++; if ({pc_write_cond, alu_op, pc_source, alu_src_a, alu_src_b, pc_write} !== 9'b1_01_1_01_00_0) begin bad++; $display("FAIL beq_ctrl got=%b exp=101101000", {pc_write_cond, alu_op, pc_source, alu_src_a, alu_src_b, pc_write}); end
    step();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL beq_return got=%0d exp=0", state); end
    opcode = 7'b1101111;
    step(); step();
    total++; if (state !== 4'd10) begin bad++; $display("FAIL jal_state got=%0d exp=10", state); end
    total++; if ({pc_write, reg_write, mem_to_reg, pc_source, pc_write_cond} !== 6'b11_10_1_0) begin bad++; $display("FAIL jal_ctrl got=%b exp=111010", {pc_write, reg_write, mem_to_reg, pc_source, pc_write_cond}); end
    step();
    total++; if (state !== 4'd0) begin bad++; $display("FAIL jal_return got=%0d exp=0", state); end
  endtask

  task automatic test_illegal();
    int bad_cyc = 0;
    mem_ready = 1'b1;
    opcode = 7'b0000000;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      if (state !== 4'd15 || err !== 1'b1 ||
          {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write} !== 6'b0) bad_cyc++;
      step();
    end
    total++; if (bad_cyc != 0) begin bad++; $display("FAIL err_sticky bad_cycles=%0d exp=0", bad_cyc); end
    rst = 1'b1;
    #1;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_in_rst got=%b exp=0", err); end
    step();
    rst = 1'b0;
    #1;
    total++; if (state !== 4'd0 || err !== 1'b0) begin bad++; $display("FAIL err_cleared state=%0d err=%b exp state=0 err=0", state, err); end
  endtask

  task automatic test_reset_midop();
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    #1;
    total++; if (state !== 4'd5 || mem_write !== 1'b1) begin bad++; $display("FAIL midrst_pre state=%0d mem_write=%b exp 5/1", state, mem_write); end
    step();
    rst = 1'b1;
    #1;
    total++; if (state !== 4'd5 || mem_write !== 1'b0) begin bad++; $display("FAIL midrst_drop state=%0d mem_write=%b exp 5/0", state, mem_write); end
    step();
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL midrst_next got=%0d exp=0", state); end
  endtask

  // Second instance ignores mem_ready: lw runs without stalls while it is low.
  task automatic test_no_ready();
    logic [3:0] es [6] = '{0, 1, 2, 3, 4, 0};
    rst = 1'b1;
    opcode = 7'b0000011;
    step();
    rst = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++; if (n_state !== es[i]) begin bad++; $display("FAIL noready_state cyc=%0d got=%0d exp=%0d", i, n_state, es[i]); end
      if (i == 0) begin
        total++; if (n_ir_write !== 1'b1 || ir_write !== 1'b0) begin bad++; $display("FAIL noready_ir n=%b main=%b exp 1/0", n_ir_write, ir_write); end
      end
      if (i < 5) step();
    end
  endtask

  initial begin
    test_reset_rtype();
    test_lw_waits();
    test_sw();
    test_beq_jal();
    test_illegal();
    test_reset_midop();
    test_no_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I-subset CPU.
- Sequences the shared ALU, memory, IR, PC and register file across IF/ID/EX/MEM/WB cycles.
- Drives alu_op to the ALU control decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- Supports add/sub, addi, lw, sw, beq and jal; stalls on memory via a ready handshake; traps illegal opcodes.

Parameters:
USE_MEM_READY, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1 (single-cycle memory).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0], valid from ID onward
mem_ready  input  1  memory completes the current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load (also latches oldPC)
mem_to_reg  output  2  write-back select: 00 = ALUOut, 01 = MDR, 10 = PC
reg_write  output  1  register file write
alu_src_a  output  2  ALU A select: 00 = PC, 01 = rs1 reg A, 10 = oldPC
alu_src_b  output  2  ALU B select: 00 = rs2 reg B, 01 = 4, 10 = imm
alu_op  output  2  to ALU control decoder
pc_source  output  1  PC input select: 0 = ALU result, 1 = ALUOut
err  output  1  illegal-opcode trap, sticky
state  output  4  current state, debug

Behaviour:
- Single 4-bit state register, synchronous reset to IF. All outputs are combinational decode of state; the IF/MEM gating below also uses mem_ready.
- While rst=1, all write/request outputs are forced 0: pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write. Remaining outputs 0; err=0.
- Signals not listed for a state are 0.
- Encodings: IF=0, ID=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EX_R=6, EX_I=7, ALU_WB=8, BEQ=9, JAL=10, ERR=15.
- IF:
  - mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0.
  - ir_write and pc_write assert only when mem_ready=1.
  - Stay in IF while mem_ready=0; else go to ID.
- ID: alu_src_a=10, alu_src_b=10, alu_op=00 (ALUOut <= oldPC+imm, branch/jump target). Next state by opcode:
  - 0110011 -> EX_R
  - 0010011 -> EX_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other -> ERR
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Next is MEM_RD for lw, MEM_WR for sw (opcode still valid).
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=01. Next is IF.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then go to IF. mem_write stays high through all wait cycles.
- EX_R: alu_src_a=01, alu_src_b=00, alu_op=10. Next is ALU_WB.
- EX_I: alu_src_a=01, alu_src_b=10, alu_op=00. addi always uses add, since funct7 is immediate bits. Next is ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00. Next is IF.
- BEQ: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1. Next is IF.
- JAL: pc_write=1, pc_source=1, reg_write=1, mem_to_reg=10 (rd <= PC, already PC+4). Next is IF.
- ERR: all enables 0, err=1. Absorbing until rst.
- Instruction latency with mem_ready=1 always:
  - lw: 5 cycles
  - add/sub, addi, sw: 4 cycles
  - beq, jal: 3 cycles
  - Each wait cycle adds 1.
- rst mid-instruction (any state, including waits): next state is IF; no write enable asserted in the rst cycle.
- USE_MEM_READY=0: the IF/MEM_RD/MEM_WR holds never occur.

Test Plan:
- Reset, then R-type: rst=1 for 2 cycles, release with opcode=0110011, mem_ready=1 -> state IF,ID,EX_R,ALU_WB,IF. alu_op=10 only in EX_R; reg_write=1 only in ALU_WB with mem_to_reg=00.
- lw with waits: opcode=0000011, mem_ready low for 2 cycles in IF and 3 in MEM_RD -> ir_write/pc_write pulse exactly once at the IF ready cycle. MEM_RD lasts 4 cycles; MEM_WB has reg_write=1, mem_to_reg=01; total 10 cycles.
- sw: opcode=0100011, mem_ready=0 for 1 cycle in MEM_WR -> mem_write=1 for 2 consecutive cycles with i_or_d=1; reg_write never 1; return to IF.
- beq and jal:
  - beq (1100011) -> BEQ has pc_write_cond=1, alu_op=01, pc_source=1.
  - jal (1101111) -> JAL has pc_write=1, reg_write=1, mem_to_reg=10.
  - Both return to IF after 3 cycles.
- Illegal opcode 0000000 -> ERR after ID; err=1 sticky for 20 cycles with all enables 0; rst=1 for one cycle -> IF, err=0.
- Reset mid-op: assert rst during MEM_WR wait -> mem_write drops to 0 in that cycle; next state IF.
